// File: rtl/uart_fft_pkg.sv
// Shared types and constants for the UART <-> FFT frame sequencer.
package uart_fft_pkg;

    localparam int         CSUM_W        = 8;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_DATA,
        ST_RX_CSUM,
        ST_FFT_START,
        ST_FFT_WAIT,
        ST_TX_HDR,
        ST_TX_DATA,
        ST_TX_CSUM
    } state_t;

endpackage

// File: rtl/uart_tx_pacer.sv
// Paces byte strobes to the UART transmitter: one strobe per idle period,
// with a guard cycle covering the one-cycle lag before TxD_busy rises.
module uart_tx_pacer (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_req,
    input  logic [7:0] send_byte,
    input  logic       TxD_busy,
    output logic       send_ack,
    output logic       TxD_start,
    output logic [7:0] TxD_data
);

    // TxD_start high means a strobe is going out now and busy has not risen yet.
    assign send_ack = send_req && !TxD_busy && !TxD_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            TxD_start <= 1'b0;
            TxD_data  <= '0;
        end else begin
            // NOTE: nonblocking, so send_ack above always sees the strobe already on the wire.
            TxD_start <= send_ack;
            if (send_ack)
                TxD_data <= send_byte;
        end
    end

endmodule

// File: rtl/uart_fft_frame_ctrl.sv
// Frame sequencer: deframes RX samples into the sample buffer, runs the FFT,
// then streams the result buffer back out through the transmitter.
module uart_fft_frame_ctrl
    import uart_fft_pkg::*;
#(
    parameter int         N_SAMPLES   = 64,
    parameter int         ADDR_W      = 6,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RxD_data_ready,
    input  logic [7:0]        RxD_data,
    output logic              TxD_start,
    output logic [7:0]        TxD_data,
    input  logic              TxD_busy,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [7:0]        buf_wr_data,
    output logic              fft_start,
    input  logic              fft_done,
    output logic [ADDR_W-1:0] res_rd_addr,
    input  logic [7:0]        res_rd_data,
    output logic              frame_err,
    output logic              busy
);

    localparam int               IDX_W    = ADDR_W + 1;
    localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic [CSUM_W-1:0] sum;
    logic [TMO_W-1:0]  tmo;
    logic              send_req;
    logic              send_ack;
    logic [7:0]        send_byte;

    assign idx_next = idx + IDX_W'(1);
    assign busy     = (state != ST_IDLE);

    always_comb begin
        send_req  = 1'b0;
        send_byte = SYNC_BYTE;
        case (state)
            ST_TX_HDR:  send_req = 1'b1;
            ST_TX_DATA: begin send_req = 1'b1; send_byte = res_rd_data; end
            ST_TX_CSUM: begin send_req = 1'b1; send_byte = sum; end
            default:    ;
        endcase
    end

    uart_tx_pacer u_pacer (
        .clk       (clk),
        .rst       (rst),
        .send_req  (send_req),
        .send_byte (send_byte),
        .TxD_busy  (TxD_busy),
        .send_ack  (send_ack),
        .TxD_start (TxD_start),
        .TxD_data  (TxD_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            sum         <= '0;
            tmo         <= '0;
            buf_wr_en   <= 1'b0;
            buf_wr_addr <= '0;
            buf_wr_data <= '0;
            fft_start   <= 1'b0;
            frame_err   <= 1'b0;
            res_rd_addr <= '0;
        end else begin
            // NOTE: strobes default low every cycle; each set below is a one-cycle pulse.
            buf_wr_en <= 1'b0;
            fft_start <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: if (RxD_data_ready && RxD_data == SYNC_BYTE) begin
                    state <= ST_RX_DATA;
                    idx   <= '0;
                    sum   <= '0;
                    tmo   <= '0;
                end
                ST_RX_DATA, ST_RX_CSUM: begin
                    if (RxD_data_ready) begin
                        tmo <= '0;
                        if (state == ST_RX_DATA) begin
                            buf_wr_en   <= 1'b1;
                            buf_wr_addr <= idx[ADDR_W-1:0];
                            buf_wr_data <= RxD_data;
                            sum         <= sum + RxD_data;
                            idx         <= idx_next;
                            if (idx == LAST_IDX)
                                state <= ST_RX_CSUM;
                        end else if (RxD_data == sum) begin
                            state     <= ST_FFT_START;
                            fft_start <= 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            frame_err <= 1'b1;
                        end
                    end else if (tmo == TMO_LAST) begin
                        // Already-written samples stay in the buffer; only the frame is dropped.
                        state     <= ST_IDLE;
                        frame_err <= 1'b1;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                ST_FFT_START: state <= ST_FFT_WAIT;
                ST_FFT_WAIT: if (fft_done) begin
                    state       <= ST_TX_HDR;
                    res_rd_addr <= '0;
                end
                ST_TX_HDR: if (send_ack) begin
                    state       <= ST_TX_DATA;
                    idx         <= '0;
                    sum         <= '0;
                    res_rd_addr <= '0;
                end
                ST_TX_DATA: if (send_ack) begin
                    // The pacer's guard cycle gives the result buffer its read latency.
                    sum         <= sum + res_rd_data;
                    idx         <= idx_next;
                    res_rd_addr <= idx_next[ADDR_W-1:0];
                    if (idx == LAST_IDX)
                        state <= ST_TX_CSUM;
                end
                ST_TX_CSUM: if (send_ack) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fft_frame_ctrl.sv
// Self-checking bench for uart_fft_frame_ctrl: table vectors, corner-case
// sequences and randomized frames against a frame-level reference model.
module tb_uart_fft_frame_ctrl;

    localparam int         N           = 4;
    localparam int         AW          = 2;
    localparam int         TMO         = 100;
    localparam int         TX_BUSY_CYC = 10;
    localparam logic [7:0] SYNC        = 8'hA5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          RxD_data_ready = 1'b0;
    logic [7:0]    RxD_data = 8'h00;
    logic          TxD_start;
    logic [7:0]    TxD_data;
    wire           TxD_busy;
    logic          buf_wr_en;
    logic [AW-1:0] buf_wr_addr;
    logic [7:0]    buf_wr_data;
    logic          fft_start;
    logic          fft_done = 1'b0;
    logic [AW-1:0] res_rd_addr;
    logic [7:0]    res_rd_data;
    logic          frame_err;
    logic          busy;

    uart_fft_frame_ctrl #(
        .N_SAMPLES   (N),
        .ADDR_W      (AW),
        .SYNC_BYTE   (SYNC),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .RxD_data_ready (RxD_data_ready),
        .RxD_data       (RxD_data),
        .TxD_start      (TxD_start),
        .TxD_data       (TxD_data),
        .TxD_busy       (TxD_busy),
        .buf_wr_en      (buf_wr_en),
        .buf_wr_addr    (buf_wr_addr),
        .buf_wr_data    (buf_wr_data),
        .fft_start      (fft_start),
        .fft_done       (fft_done),
        .res_rd_addr    (res_rd_addr),
        .res_rd_data    (res_rd_data),
        .frame_err      (frame_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Environment models: transmitter busy window, result buffer, cycle count.
    int         tx_cnt = 0;
    int         cyc = 0;
    logic [7:0] res_mem [N];

    assign TxD_busy = (tx_cnt != 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (TxD_start) tx_cnt <= TX_BUSY_CYC;
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
        res_rd_data <= res_mem[res_rd_addr];
    end

    // Observation logs, sampled on the falling edge.
    logic [AW+7:0] wr_q [$];
    logic [7:0]    tx_q [$];
    int            n_fft_cyc = 0;
    int            n_err = 0;
    int            n_guard = 0;

    always @(negedge clk) begin
        if (buf_wr_en) wr_q.push_back({buf_wr_addr, buf_wr_data});
        if (TxD_start) begin
            tx_q.push_back(TxD_data);
            if (TxD_busy) n_guard++;
        end
        if (fft_start) n_fft_cyc++;
        if (frame_err) n_err++;
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    int         last_strobe = 0;
    int         fft0 = 0;
    int         err0 = 0;
    logic [7:0] frame_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input int gap);
        RxD_data       = b;
        RxD_data_ready = 1'b1;
        @(negedge clk);
        RxD_data_ready = 1'b0;
        RxD_data       = 8'($urandom);
        last_strobe    = cyc;
        tick(gap);
    endtask

    task automatic snapshot();
        wr_q.delete();
        fft0 = n_fft_cyc;
        err0 = n_err;
    endtask

    task automatic send_frame(input int gap);
        foreach (frame_q[i]) send_rx(frame_q[i], gap);
        tick(3);
    endtask

    function automatic int sync_pos();
        for (int i = 0; i < frame_q.size(); i++)
            if (frame_q[i] == SYNC) return i;
        return -1;
    endfunction

    // Reference: samples after the first sync byte are written in order to addresses 0..N-1.
    task automatic check_rx(input string tag, input bit exp_fft, input bit exp_err, input int exp_writes);
        int p;
        p = sync_pos();
        check({tag, "_fft_cycles"}, 32'(n_fft_cyc - fft0), 32'(exp_fft));
        check({tag, "_frame_err"}, 32'(n_err - err0), 32'(exp_err));
        check({tag, "_wr_count"}, 32'(wr_q.size()), 32'(exp_writes));
        for (int i = 0; i < exp_writes && i < wr_q.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), 32'(wr_q[i]), 32'({AW'(i), frame_q[p + 1 + i]}));
        check({tag, "_busy"}, 32'(busy), 32'(exp_fft));
    endtask

    // Reference: TX stream is sync, the N results, then their modulo-256 sum.
    task automatic run_tx(input string tag, input logic [31:0] res);
        logic [7:0] exp_b [$];
        logic [7:0] s;
        int         k;
        s = 8'h00;
        exp_b.delete();
        exp_b.push_back(SYNC);
        for (int i = 0; i < N; i++) begin
            res_mem[i] = res[31 - 8*i -: 8];
            exp_b.push_back(res_mem[i]);
            s = s + res_mem[i];
        end
        exp_b.push_back(s);
        tx_q.delete();
        fft_done = 1'b1;
        tick(1);
        fft_done = 1'b0;
        k = 0;
        while (tx_q.size() < N + 2 && k < 500) begin
            tick(1);
            k++;
        end
        tick(2);
        check({tag, "_tx_count"}, 32'(tx_q.size()), 32'(N + 2));
        for (int i = 0; i < N + 2 && i < tx_q.size(); i++)
            check($sformatf("%s_tx%0d", tag, i), 32'(tx_q[i]), 32'(exp_b[i]));
        check({tag, "_busy_after_tx"}, 32'(busy), 32'(0));
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({TxD_start, TxD_data, buf_wr_en, buf_wr_addr, buf_wr_data,
                    fft_start, res_rd_addr, frame_err, busy});
    endfunction

    typedef struct packed {
        logic [63:0] frame;      // bytes in send order, leftmost first
        logic [3:0]  len;
        logic [31:0] res;        // FFT results for the TX phase, leftmost first
        logic        exp_fft;
        logic        exp_err;
        logic [3:0]  exp_writes;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int k;
        int lat;
        logic [7:0] s;
        logic [7:0] pay;
        bit bad;

        vecs[0] = '{64'hA5_01_02_03_04_0A_00_00, 4'd6, 32'h10_20_30_40, 1'b1, 1'b0, 4'd4};
        vecs[1] = '{64'hA5_01_02_03_04_0B_00_00, 4'd6, 32'h0,          1'b0, 1'b1, 4'd4};
        vecs[2] = '{64'h00_FF_A5_05_05_05_05_14, 4'd8, 32'h01_02_03_04, 1'b1, 1'b0, 4'd4};
        vecs[3] = '{64'hA5_FF_FF_FF_FF_FC_00_00, 4'd6, 32'hFF_FF_FF_FF, 1'b1, 1'b0, 4'd4};
        vecs[4] = '{64'hA5_A5_A5_A5_A5_94_00_00, 4'd6, 32'h80_80_80_80, 1'b1, 1'b0, 4'd4};
        for (int i = 0; i < N; i++) res_mem[i] = 8'h00;

        tick(3);
        check("reset_outputs", out_vec(), 32'(0));
        rst = 1'b0;
        tick(2);

        foreach (vecs[v]) begin
            frame_q.delete();
            for (int i = 0; i < vecs[v].len; i++)
                frame_q.push_back(vecs[v].frame[63 - 8*i -: 8]);
            snapshot();
            send_frame(2);
            check_rx($sformatf("vec%0d", v), vecs[v].exp_fft, vecs[v].exp_err, int'(vecs[v].exp_writes));
            if (vecs[v].exp_fft) run_tx($sformatf("vec%0d", v), vecs[v].res);
        end

        // fft_done outside FFT_WAIT must not start a transmission.
        tx_q.delete();
        fft_done = 1'b1;
        tick(3);
        fft_done = 1'b0;
        tick(15);
        check("idle_fft_done_busy", 32'(busy), 32'(0));
        check("idle_fft_done_tx", 32'(tx_q.size()), 32'(0));

        // Inter-byte timeout, partial write kept, then recovery with RX during FFT_WAIT ignored.
        snapshot();
        send_rx(SYNC, 2);
        send_rx(8'h01, 0);
        k = last_strobe;
        while (!frame_err && cyc - k < TMO + 20) tick(1);
        lat = cyc - k;
        check("timeout_latency", 32'(lat), 32'(TMO));
        tick(2);
        check("timeout_err_count", 32'(n_err - err0), 32'(1));
        check("timeout_busy", 32'(busy), 32'(0));
        check("timeout_partial_wr", 32'(wr_q.size()), 32'(1));
        frame_q = '{SYNC, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        snapshot();
        send_frame(3);
        check_rx("after_tmo", 1'b1, 1'b0, N);
        snapshot();
        send_rx(SYNC, 1);
        send_rx(8'h33, 3);
        check("fftwait_rx_writes", 32'(wr_q.size()), 32'(0));
        check("fftwait_rx_err", 32'(n_err - err0), 32'(0));
        run_tx("after_tmo", 32'h0A_0B_0C_0D);

        // Reset in the middle of TX_DATA.
        frame_q = '{SYNC, 8'h09, 8'h08, 8'h07, 8'h06, 8'h1E};
        snapshot();
        send_frame(2);
        check_rx("pre_rst", 1'b1, 1'b0, N);
        for (int i = 0; i < N; i++) res_mem[i] = 8'h5A + 8'(i);
        tx_q.delete();
        fft_done = 1'b1;
        tick(1);
        fft_done = 1'b0;
        k = 0;
        while (tx_q.size() < 2 && k < 100) begin tick(1); k++; end
        check("pre_rst_tx_count", 32'(tx_q.size()), 32'(2));
        rst = 1'b1;
        tick(1);
        check("mid_tx_reset_outputs", out_vec(), 32'(0));
        rst = 1'b0;
        tick(15);
        frame_q = '{SYNC, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0};
        snapshot();
        send_frame(2);
        check_rx("post_rst", 1'b1, 1'b0, N);
        run_tx("post_rst", 32'hDE_AD_BE_EF);

        // Randomized frames: noise prefix, random gaps, occasional bad checksum.
        for (int it = 0; it < 16; it++) begin
            frame_q.delete();
            bad = ($urandom_range(0, 3) == 0);
            s = 8'h00;
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) frame_q.push_back(8'($urandom_range(0, 164)));
            frame_q.push_back(SYNC);
            for (int j = 0; j < N; j++) begin
                pay = 8'($urandom);
                s = s + pay;
                frame_q.push_back(pay);
            end
            frame_q.push_back(bad ? s + 8'($urandom_range(1, 255)) : s);
            snapshot();
            send_frame($urandom_range(0, 6));
            check_rx($sformatf("rnd%0d", it), !bad, bad, N);
            if (!bad) run_tx($sformatf("rnd%0d", it), $urandom);
        end

        check("tx_guard_violations", 32'(n_guard), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
